uart_packet_rx: RTL and testbench
=================================

UART_PACKET_RX -- requirements
Module: uart_packet_rx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 434, clk50M cycles per UART bit (115200 baud at 50 MHz).
REQ-002 SHALL provide parameter TIMEOUT_BITS, default 20, inter-byte timeout in bit periods.
REQ-003 SHALL have port clk50M  input  1  system clock; the single clock for all logic.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port uart_rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port byte_data_received  output  16  last packet: [15:8] channel address, [7:0] value.
REQ-007 SHALL have port byte_received  output  1  one-cycle strobe; byte_data_received is valid on and after this cycle.
REQ-008 SHALL have port frame_error  output  1  one-cycle pulse on a bad stop bit.

Function
REQ-009 SHALL pass uart_rx through a 2-flop synchronizer; all sampling SHALL use the synchronized value.
REQ-010 SHALL implement states IDLE, START, DATA, STOP, BREAK, driven by a bit-timing counter that reloads on every state change.
REQ-011 IDLE: synchronized line low -> START.
REQ-012 START: after CLKS_PER_BIT/2 cycles (integer division), sample; low -> DATA; high -> IDLE (glitch, nothing recorded).
REQ-013 DATA: sample every CLKS_PER_BIT cycles, shift in LSB first; after the 8th sample -> STOP.
REQ-014 STOP: after CLKS_PER_BIT cycles, sample; high -> byte accepted, IDLE; low -> frame_error pulse, byte discarded, packet phase cleared to 0, -> BREAK.
REQ-015 BREAK: stay until synchronized line high, then -> IDLE; no start detection while in BREAK.
REQ-016 Packet phase bit: phase 0 -> accepted byte stored as address, phase becomes 1; phase 1 -> accepted byte is value, phase becomes 0.
REQ-017 On phase-1 acceptance, byte_data_received SHALL load {address, value} and byte_received SHALL be high for exactly the next cycle after the stop-bit sample.
REQ-018 byte_data_received SHALL hold its value until the next complete packet; it SHALL NOT change on address bytes, errors or timeouts.
REQ-019 Timeout: while phase = 1 and state = IDLE, count cycles; reaching TIMEOUT_BITS*CLKS_PER_BIT clears phase to 0 (stray address dropped, no output activity). Counter clears on any start detection.
REQ-020 A start bit and timeout expiry in the same cycle: timeout wins; the new byte is treated as an address.
REQ-021 Back-to-back frames (start bit immediately after stop sample) SHALL be received without loss.
REQ-022 byte_received and frame_error SHALL never be high in the same cycle.
REQ-023 Counter widths SHALL be sized from the parameters with no wrap-around before terminal count.

Reset
REQ-024 While rst is high at a clk50M edge: state IDLE, phase 0, all counters 0, synchronizer flops 1, byte_data_received 16'h0000, byte_received 0, frame_error 0.
REQ-025 Reset asserted mid-frame or mid-packet SHALL abort it with no strobe; the next start bit after release begins an address byte.

Verification (CLKS_PER_BIT=8, TIMEOUT_BITS=20)
REQ-026 Send bytes 0x02, 0x80 back-to-back -> one byte_received pulse, byte_data_received = 16'h0280, frame_error never high.
REQ-027 Send 0x01 with stop bit low, then 0x03, 0x55 -> one frame_error pulse, then byte_data_received = 16'h0355 with one strobe.
REQ-028 Send 0x01, idle 200 cycles, send 0x03, 0x10 -> no strobe for 0x01/0x03 pairing; strobe with 16'h0310 after 0x10... phase check: 0x03 is address, output 16'h0310.
REQ-029 Low glitch of 3 cycles on idle line -> no state progress past START, no outputs, phase unchanged.
REQ-030 Assert rst during bit 4 of the value byte after address 0x02 -> no strobe, outputs 0; then 0x01, 0xFF -> 16'h01FF.
REQ-031 Hold line low 30 bit periods then release, then send 0x02, 0x40 -> exactly one frame_error, then 16'h0240 with one strobe.

Source files
------------

// File: rtl/uart_packet_rx.sv
// 8N1 UART receiver that pairs consecutive bytes into {address, value} packets.
// Stray addresses are dropped after an inter-byte timeout; bad stop bits raise frame_error.
module uart_packet_rx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        clk50M,
  input  logic        rst,
  input  logic        uart_rx,
  output logic [15:0] byte_data_received,
  output logic        byte_received,
  output logic        frame_error
);

  localparam int unsigned HALF_LAST = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0;
  localparam int unsigned BIT_LAST  = (CLKS_PER_BIT > 0) ? CLKS_PER_BIT - 1 : 0;
  localparam int unsigned CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned TO_LIMIT  = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TO_LAST   = (TO_LIMIT > 0) ? TO_LIMIT - 1 : 0;
  localparam int unsigned TO_W      = (TO_LIMIT > 1) ? $clog2(TO_LIMIT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              sync1;
  logic              sync2;
  logic [CNT_W-1:0]  bit_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              phase;
  logic [7:0]        addr;
  logic [TO_W-1:0]   to_cnt;

  logic              tick_c;
  logic              start_det_c;
  logic              shift_c;
  logic              accept_c;
  logic              ferr_c;
  logic              timeout_c;

  // State register
  always_ff @(posedge clk50M) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle event decode
  always_comb begin
    state_next  = state;
    tick_c      = 1'b0;
    start_det_c = 1'b0;
    shift_c     = 1'b0;
    accept_c    = 1'b0;
    ferr_c      = 1'b0;
    case (state)
      IDLE: begin
        if (!sync2) begin
          start_det_c = 1'b1;
          state_next  = START;
        end
      end
      START: begin
        if (bit_cnt == CNT_W'(HALF_LAST)) begin
          tick_c     = 1'b1;
          state_next = sync2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_cnt == CNT_W'(BIT_LAST)) begin
          tick_c  = 1'b1;
          shift_c = 1'b1;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (bit_cnt == CNT_W'(BIT_LAST)) begin
          tick_c = 1'b1;
          if (sync2) begin
            accept_c   = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_c     = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        if (sync2) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    timeout_c = (state == IDLE) && phase && (to_cnt == TO_W'(TO_LAST));
  end

  // Synchronizer, bit timing, packet assembly and registered outputs
  always_ff @(posedge clk50M) begin
    if (rst) begin
      sync1              <= 1'b1;
      sync2              <= 1'b1;
      bit_cnt            <= '0;
      bit_idx            <= '0;
      shift              <= '0;
      phase              <= 1'b0;
      addr               <= '0;
      to_cnt             <= '0;
      byte_data_received <= '0;
      byte_received      <= 1'b0;
      frame_error        <= 1'b0;
    end else begin
      sync1         <= uart_rx;
      sync2         <= sync1;
      byte_received <= 1'b0;
      frame_error   <= 1'b0;

      if ((state_next != state) || tick_c || (state == IDLE) || (state == BREAK)) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      if (state != DATA) begin
        bit_idx <= '0;
      end else if (shift_c) begin
        bit_idx <= bit_idx + 3'd1;
      end

      if (shift_c) begin
        shift <= {sync2, shift[7:1]};
      end

      // Timeout and stop-bit outcomes occur in different states, so they never collide
      if (timeout_c) begin
        phase <= 1'b0;
      end else if (ferr_c) begin
        phase       <= 1'b0;
        frame_error <= 1'b1;
      end else if (accept_c) begin
        if (!phase) begin
          addr  <= shift;
          phase <= 1'b1;
        end else begin
          byte_data_received <= {addr, shift};
          byte_received      <= 1'b1;
          phase              <= 1'b0;
        end
      end

      if ((state != IDLE) || !phase || start_det_c || timeout_c) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_packet_rx.sv
// Self-checking bench for uart_packet_rx: directed scenarios plus randomized byte
// streams scored against a packet-level model of address/value pairing.
module tb_uart_packet_rx;

  localparam int unsigned CPB     = 8;
  localparam int unsigned TO_BITS = 20;

  logic        clk50M = 1'b0;
  logic        rst;
  logic        uart_rx;
  logic [15:0] byte_data_received;
  logic        byte_received;
  logic        frame_error;

  uart_packet_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TO_BITS)
  ) dut (
    .clk50M(clk50M),
    .rst(rst),
    .uart_rx(uart_rx),
    .byte_data_received(byte_data_received),
    .byte_received(byte_received),
    .frame_error(frame_error)
  );

  always #5 clk50M = ~clk50M;

  typedef struct packed {
    logic        is_err;
    logic [15:0] data;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          strobe_cnt = 0;
  int          ferr_cnt = 0;
  int          rst_run = 0;
  logic [15:0] shown_out = '0;
  bit          m_phase = 1'b0;
  logic [7:0]  m_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the expected event stream
  always @(negedge clk50M) begin
    logic [1:0] kind;
    ev_t        ev;
    if (rst) begin
      rst_run++;
      shown_out = '0;
      if (rst_run >= 2) begin
        check("rst_strobe", 32'(byte_received), 32'd0);
        check("rst_ferr", 32'(frame_error), 32'd0);
        check("rst_data", 32'(byte_data_received), 32'd0);
      end
    end else begin
      rst_run = 0;
      kind = (exp_q.size() == 0) ? 2'd0 : (exp_q[0].is_err ? 2'd2 : 2'd1);
      check("exclusive", 32'(byte_received & frame_error), 32'd0);
      if (byte_received) begin
        strobe_cnt++;
        check("strobe_event_kind", 32'(kind), 32'd1);
        if (kind == 2'd1) begin
          ev = exp_q.pop_front();
          shown_out = ev.data;
        end
      end
      if (frame_error) begin
        ferr_cnt++;
        check("ferr_event_kind", 32'(kind), 32'd2);
        if (kind == 2'd2) begin
          ev = exp_q.pop_front();
        end
      end
      check("data_hold", 32'(byte_data_received), 32'(shown_out));
    end
  end

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(posedge clk50M);
  endtask

  // Idle long enough that any pending address must have timed out
  task automatic idle_long(input int n);
    idle(n);
    m_phase = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    ev_t e;
    if (stop_ok) begin
      if (!m_phase) begin
        m_addr  = b;
        m_phase = 1'b1;
      end else begin
        e.is_err = 1'b0;
        e.data   = {m_addr, b};
        exp_q.push_back(e);
        m_phase = 1'b0;
      end
    end else begin
      e.is_err = 1'b1;
      e.data   = '0;
      exp_q.push_back(e);
      m_phase = 1'b0;
    end
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk50M);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge clk50M);
    end
    uart_rx = stop_ok;
    repeat (CPB) @(posedge clk50M);
    uart_rx = 1'b1;
  endtask

  task automatic glitch(input int n);
    uart_rx = 1'b0;
    repeat (n) @(posedge clk50M);
    uart_rx = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int         s0;
    int         f0;
    logic [7:0] v;
    logic [7:0] rb;
    bit         ok;
    int         gap;

    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (4) @(posedge clk50M);
    rst = 1'b0;
    idle(10);
    @(negedge clk50M);
    check("reset_data", 32'(byte_data_received), 32'h0000);
    check("reset_strobe", 32'(byte_received), 32'd0);

    // Back-to-back address/value pair
    s0 = strobe_cnt; f0 = ferr_cnt;
    send_byte(8'h02, 1'b1);
    send_byte(8'h80, 1'b1);
    idle(30);
    @(negedge clk50M);
    check("b2b_data", 32'(byte_data_received), 32'h0280);
    check("b2b_strobes", 32'(strobe_cnt - s0), 32'd1);
    check("b2b_ferr", 32'(ferr_cnt - f0), 32'd0);

    // Bad stop bit discards the byte and restarts pairing
    s0 = strobe_cnt; f0 = ferr_cnt;
    send_byte(8'h01, 1'b0);
    idle(20);
    send_byte(8'h03, 1'b1);
    send_byte(8'h55, 1'b1);
    idle(30);
    @(negedge clk50M);
    check("ferr_count", 32'(ferr_cnt - f0), 32'd1);
    check("ferr_data", 32'(byte_data_received), 32'h0355);
    check("ferr_strobes", 32'(strobe_cnt - s0), 32'd1);

    // Timeout drops a stray address
    s0 = strobe_cnt;
    send_byte(8'h01, 1'b1);
    idle_long(200);
    @(negedge clk50M);
    check("timeout_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    check("timeout_hold", 32'(byte_data_received), 32'h0355);
    send_byte(8'h03, 1'b1);
    send_byte(8'h10, 1'b1);
    idle(30);
    @(negedge clk50M);
    check("timeout_data", 32'(byte_data_received), 32'h0310);
    check("timeout_strobes", 32'(strobe_cnt - s0), 32'd1);

    // Short glitch between address and value leaves the phase intact
    s0 = strobe_cnt; f0 = ferr_cnt;
    send_byte(8'h11, 1'b1);
    idle(5);
    glitch(3);
    idle(20);
    @(negedge clk50M);
    check("glitch_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    check("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    send_byte(8'h22, 1'b1);
    idle(20);
    @(negedge clk50M);
    check("glitch_data", 32'(byte_data_received), 32'h1122);

    // Reset in the middle of a value byte
    s0 = strobe_cnt;
    send_byte(8'h02, 1'b1);
    v = 8'hA5;
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk50M);
    for (int i = 0; i < 4; i++) begin
      uart_rx = v[i];
      repeat (CPB) @(posedge clk50M);
    end
    uart_rx = v[4];
    repeat (3) @(posedge clk50M);
    rst = 1'b1;
    m_phase = 1'b0;
    uart_rx = 1'b1;
    repeat (4) @(posedge clk50M);
    rst = 1'b0;
    idle(20);
    @(negedge clk50M);
    check("midrst_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    check("midrst_data", 32'(byte_data_received), 32'h0000);
    send_byte(8'h01, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(20);
    @(negedge clk50M);
    check("midrst_after", 32'(byte_data_received), 32'h01FF);

    // Line held low for 30 bit periods (break)
    s0 = strobe_cnt; f0 = ferr_cnt;
    begin
      ev_t e;
      e.is_err = 1'b1;
      e.data   = '0;
      exp_q.push_back(e);
      m_phase = 1'b0;
    end
    uart_rx = 1'b0;
    repeat (30 * CPB) @(posedge clk50M);
    idle(20);
    send_byte(8'h02, 1'b1);
    send_byte(8'h40, 1'b1);
    idle(20);
    @(negedge clk50M);
    check("break_ferr", 32'(ferr_cnt - f0), 32'd1);
    check("break_data", 32'(byte_data_received), 32'h0240);
    check("break_strobes", 32'(strobe_cnt - s0), 32'd1);

    // Randomized byte stream: bad stops, back-to-back frames, glitches, timeouts
    for (int n = 0; n < 80; n++) begin
      rb = 8'($urandom);
      ok = ($urandom_range(0, 9) != 0);
      send_byte(rb, ok);
      if ($urandom_range(0, 4) == 0) begin
        idle_long(200 + int'($urandom_range(0, 60)));
      end else begin
        gap = ok ? int'($urandom_range(0, 60)) : int'($urandom_range(20, 60));
        if (gap >= 20 && $urandom_range(0, 2) == 0) begin
          idle(3);
          glitch(int'($urandom_range(1, 3)));
          idle(gap - 6);
        end else begin
          idle(gap);
        end
      end
    end

    idle(60);
    @(negedge clk50M);
    check("pending_events", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
